cache_miss_sequencer: RTL and testbench

- Per-set miss/allocate controller sitting between the cache controller's lookup stage and the eviction policy block.
- On a hit it forwards the one-hot hit way to the policy.
- On a miss it picks a victim: the lowest invalid way first, otherwise the policy's evictionTarget. It then sequences writeback of a dirty victim and the line fill, and finally pulses allocateWay to the policy.
- Only one miss is in flight at a time.

---
 rtl/cache_miss_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cache_miss_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_sequencer.sv
// Per-set miss/allocate sequencer: victim pick, dirty writeback, line fill, allocate pulse; min miss latency 4 cycles to req_ready.
// Accepts one lookup in IDLE only and holds wb/fill requests until acknowledged; EVICT_TIMEOUT_EN adds a round-robin fallback victim.
module cache_miss_sequencer #(
  parameter int NUM_WAYS       = 4,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_hit,
  input  logic [NUM_WAYS-1:0]      req_hit_way,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_WAYS-1:0]      valid_mask,
  input  logic [NUM_WAYS-1:0]      dirty_mask,
  output logic [NUM_WAYS-1:0]      hitWay,
  output logic [NUM_WAYS-1:0]      allocateWay,
  input  logic [NUM_WAYS-1:0]      evictionTarget,
  input  logic                     evictionReady,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [NUM_WAYS-1:0]      wb_way,
  output logic                     fill_valid,
  input  logic                     fill_ready,
  output logic [ADDRESS_WIDTH-1:0] fill_addr,
  input  logic                     fill_done,
  output logic                     done,
  output logic                     protocol_err
);

  typedef enum logic [2:0] {
    IDLE, EVICT_WAIT, WRITEBACK, FILL_REQ, FILL_WAIT, ALLOCATE
  } state_t;

  localparam logic [NUM_WAYS-1:0] WAY0 = {{(NUM_WAYS-1){1'b0}}, 1'b1};

  state_t                     state;
  logic [ADDRESS_WIDTH-1:0]   addrLat;
  logic [NUM_WAYS-1:0]        dirtyLat;
  logic [NUM_WAYS-1:0]        victim;
  logic                       evictTake;
  logic                       evictBad;
  logic [NUM_WAYS-1:0]        evictPick;
  logic [NUM_WAYS-1:0]        invalidMask;

  // Lowest set bit as one-hot; an empty vector falls back to way 0.
  function automatic logic [NUM_WAYS-1:0] lowestOne(input logic [NUM_WAYS-1:0] v);
    logic [NUM_WAYS-1:0] r;
    r = v & (~v + WAY0);
    return (v == '0) ? WAY0 : r;
  endfunction

  function automatic logic isOneHot(input logic [NUM_WAYS-1:0] v);
    return (v != '0) && ((v & (v - WAY0)) == '0);
  endfunction

  assign invalidMask = ~valid_mask;
  assign req_ready   = (state == IDLE) && !reset;

`ifdef EVICT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RR_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [CNT_W-1:0]    timeoutCnt;
  logic [RR_W-1:0]     rrIdx;
  logic [NUM_WAYS-1:0] rrWay;
  logic                timeoutFire;

  assign rrWay       = WAY0 << rrIdx;
  assign timeoutFire = (state == EVICT_WAIT) && !evictionReady &&
                       (timeoutCnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeoutCnt <= '0;
      rrIdx      <= '0;
    end else begin
      if (state == EVICT_WAIT && !evictTake) timeoutCnt <= timeoutCnt + CNT_W'(1);
      else                                   timeoutCnt <= '0;
      if (timeoutFire) begin
        if (rrIdx == RR_W'(NUM_WAYS - 1)) rrIdx <= '0;
        else                              rrIdx <= rrIdx + RR_W'(1);
      end
    end
  end
`endif

  always_comb begin
    evictTake = 1'b0;
    evictBad  = 1'b0;
    evictPick = lowestOne(evictionTarget);
    if (state == EVICT_WAIT) begin
      if (evictionReady) begin
        evictTake = 1'b1;
        evictBad  = !isOneHot(evictionTarget);
      end
`ifdef EVICT_TIMEOUT_EN
      else if (timeoutFire) begin
        evictTake = 1'b1;
        evictPick = rrWay;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addrLat      <= '0;
      dirtyLat     <= '0;
      victim       <= '0;
      hitWay       <= '0;
      allocateWay  <= '0;
      done         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_way       <= '0;
      fill_valid   <= 1'b0;
      fill_addr    <= '0;
      protocol_err <= 1'b0;
    end else begin
      hitWay      <= '0;
      allocateWay <= '0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_hit) begin
              hitWay <= req_hit_way;
            end else begin
              addrLat  <= req_addr;
              dirtyLat <= dirty_mask;
              // An invalid way never needs writeback or a policy decision.
              if (invalidMask != '0) begin
                victim     <= lowestOne(invalidMask);
                fill_valid <= 1'b1;
                fill_addr  <= req_addr;
                state      <= FILL_REQ;
              end else begin
                state <= EVICT_WAIT;
              end
            end
          end
        end
        EVICT_WAIT: begin
          if (evictTake) begin
            victim <= evictPick;
            if (evictBad) protocol_err <= 1'b1;
            if ((evictPick & dirtyLat) != '0) begin
              wb_valid <= 1'b1;
              wb_way   <= evictPick;
              state    <= WRITEBACK;
            end else begin
              fill_valid <= 1'b1;
              fill_addr  <= addrLat;
              state      <= FILL_REQ;
            end
          end
        end
        WRITEBACK: begin
          if (wb_ready) begin
            wb_valid   <= 1'b0;
            fill_valid <= 1'b1;
            fill_addr  <= addrLat;
            state      <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (fill_ready) begin
            fill_valid <= 1'b0;
            state      <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (fill_done) begin
            allocateWay <= victim;
            done        <= 1'b1;
            state       <= ALLOCATE;
          end
        end
        ALLOCATE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Directed bench for cache_miss_sequencer: vector table of complete transactions plus hand-timed corner sequences.
module tb_cache_miss_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_hit;
  logic [3:0]  req_hit_way, valid_mask, dirty_mask;
  logic [31:0] req_addr, fill_addr;
  logic [3:0]  hitWay, allocateWay, evictionTarget, wb_way;
  logic        evictionReady, wb_valid, wb_ready, fill_valid, fill_ready, fill_done;
  logic        done, protocol_err;

  int checks = 0;
  int failures = 0;
  int lat;

  cache_miss_sequencer #(.NUM_WAYS(4), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_hit(req_hit),
    .req_hit_way(req_hit_way), .req_addr(req_addr),
    .valid_mask(valid_mask), .dirty_mask(dirty_mask),
    .hitWay(hitWay), .allocateWay(allocateWay),
    .evictionTarget(evictionTarget), .evictionReady(evictionReady),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_way(wb_way),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .fill_done(fill_done), .done(done), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [3:0]  hitIn;
    logic [31:0] addr;
    logic [3:0]  vmask;
    logic [3:0]  dmask;
    logic [3:0]  target;
    logic        rdy;
    logic [3:0]  expHit;
    logic [3:0]  expAlloc;
    logic        expWb;
    logic [3:0]  expWbWay;
    logic        expPerr;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    req_valid = 0; req_hit = 0; req_hit_way = 0; req_addr = 0;
    valid_mask = 0; dirty_mask = 0; evictionTarget = 0; evictionReady = 0;
    wb_ready = 0; fill_ready = 0; fill_done = 0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_hitWay"}, {28'd0, hitWay}, 0);
    check({tag, "_allocateWay"}, {28'd0, allocateWay}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_wb_valid"}, {31'd0, wb_valid}, 0);
    check({tag, "_fill_valid"}, {31'd0, fill_valid}, 0);
    check({tag, "_protocol_err"}, {31'd0, protocol_err}, 0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 0);
  endtask

  // Runs one lookup with immediate downstream handshakes and checks the observed result.
  task automatic runTxn(input vec_t v, input string tag);
    logic [3:0]  gotAlloc, gotWbWay;
    logic [31:0] gotFill;
    logic        gotWb, gotDone, overlap;
    check({tag, "_req_ready_pre"}, {31'd0, req_ready}, 1);
    req_valid = 1; req_hit = v.hit; req_hit_way = v.hitIn; req_addr = v.addr;
    valid_mask = v.vmask; dirty_mask = v.dmask;
    evictionTarget = v.target; evictionReady = v.rdy;
    wb_ready = 1; fill_ready = 1; fill_done = 1;
    step();
    req_valid = 0;
    if (v.hit) begin
      check({tag, "_hitWay"}, {28'd0, hitWay}, {28'd0, v.expHit});
      check({tag, "_hit_alloc"}, {28'd0, allocateWay}, 0);
      check({tag, "_hit_ready"}, {31'd0, req_ready}, 1);
      step();
      check({tag, "_hitWay_clear"}, {28'd0, hitWay}, 0);
    end else begin
      gotAlloc = 0; gotWbWay = 0; gotFill = 0; gotWb = 0; gotDone = 0; overlap = 0;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
        if (wb_valid) begin gotWb = 1; gotWbWay = wb_way; end
        if (fill_valid) gotFill = fill_addr;
        if (allocateWay != 0) gotAlloc = allocateWay;
        if (hitWay != 0) overlap = 1;
        if (done) begin gotDone = 1; lat = c; break; end
        step();
      end
      check({tag, "_done_seen"}, {31'd0, gotDone}, 1);
      check({tag, "_allocateWay"}, {28'd0, gotAlloc}, {28'd0, v.expAlloc});
      check({tag, "_wb_seen"}, {31'd0, gotWb}, {31'd0, v.expWb});
      if (v.expWb) check({tag, "_wb_way"}, {28'd0, gotWbWay}, {28'd0, v.expWbWay});
      check({tag, "_fill_addr"}, gotFill, v.addr);
      check({tag, "_no_hit_pulse"}, {31'd0, overlap}, 0);
      step();
      check({tag, "_ready_after"}, {31'd0, req_ready}, 1);
      check({tag, "_done_clear"}, {31'd0, done}, 0);
    end
    check({tag, "_protocol_err"}, {31'd0, protocol_err}, {31'd0, v.expPerr});
    idleInputs();
  endtask

  initial begin
    //          hit hitIn   addr        vmask    dmask    target   rdy expHit   expAlloc wb wbWay    perr
    vecs[0] = '{1, 4'b0100, 32'h0,     4'b1111, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0000, 0, 4'b0000, 0};
    vecs[1] = '{1, 4'b0001, 32'h0,     4'b1111, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 0, 4'b0000, 0};
    vecs[2] = '{0, 4'b0000, 32'h1000,  4'b1011, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0100, 0, 4'b0000, 0};
    vecs[3] = '{0, 4'b0000, 32'h1040,  4'b0000, 4'b0000, 4'b1000, 1, 4'b0000, 4'b0001, 0, 4'b0000, 0};
    vecs[4] = '{0, 4'b0000, 32'h1080,  4'b0111, 4'b1111, 4'b0001, 1, 4'b0000, 4'b1000, 0, 4'b0000, 0};
    vecs[5] = '{0, 4'b0000, 32'h10C0,  4'b1111, 4'b0000, 4'b1000, 1, 4'b0000, 4'b1000, 0, 4'b0000, 0};
    vecs[6] = '{0, 4'b0000, 32'hABC0,  4'b1111, 4'b0100, 4'b0100, 1, 4'b0000, 4'b0100, 1, 4'b0100, 0};
    vecs[7] = '{0, 4'b0000, 32'h2000,  4'b1111, 4'b0010, 4'b0110, 1, 4'b0000, 4'b0010, 1, 4'b0010, 1};
    vecs[8] = '{0, 4'b0000, 32'h2040,  4'b1111, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0001, 0, 4'b0000, 1};

    idleInputs();
    reset = 1;
    #2;
    checkAllZero("reset");
    step();
    reset = 0;
    step();

    // Minimum-latency miss, cycle by cycle.
    check("min_ready", {31'd0, req_ready}, 1);
    req_valid = 1; req_hit = 0; valid_mask = 4'b1011; req_addr = 32'h1000;
    fill_ready = 1;
    step();
    req_valid = 0;
    check("min_c1_fill_valid", {31'd0, fill_valid}, 1);
    check("min_c1_fill_addr", fill_addr, 32'h1000);
    check("min_c1_wb_valid", {31'd0, wb_valid}, 0);
    check("min_c1_ready", {31'd0, req_ready}, 0);
    fill_done = 1;
    step();
    check("min_c2_fill_valid", {31'd0, fill_valid}, 0);
    check("min_c2_done", {31'd0, done}, 0);
    step();
    check("min_c3_alloc", {28'd0, allocateWay}, 4'b0100);
    check("min_c3_done", {31'd0, done}, 1);
    idleInputs();
    step();
    check("min_c4_ready", {31'd0, req_ready}, 1);
    check("min_c4_done", {31'd0, done}, 0);
    check("min_c4_alloc", {28'd0, allocateWay}, 0);

    // Full set, dirty victim, late policy answer and writeback stalls.
    req_valid = 1; req_hit = 0; valid_mask = 4'hF; dirty_mask = 4'b0010; req_addr = 32'h3300;
    step();
    req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      check("dirty_evict_wait_wb", {31'd0, wb_valid}, 0);
      check("dirty_evict_wait_fill", {31'd0, fill_valid}, 0);
      step();
    end
    evictionTarget = 4'b0010; evictionReady = 1;
    step();
    evictionReady = 0; evictionTarget = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      check("dirty_wb_valid", {31'd0, wb_valid}, 1);
      check("dirty_wb_way", {28'd0, wb_way}, 4'b0010);
      check("dirty_wb_nofill", {31'd0, fill_valid}, 0);
      if (i == 2) wb_ready = 1;
      step();
    end
    wb_ready = 0;
    check("dirty_wb_dropped", {31'd0, wb_valid}, 0);
    check("dirty_fill_valid", {31'd0, fill_valid}, 1);
    check("dirty_fill_addr", fill_addr, 32'h3300);
    fill_ready = 1;
    step();
    fill_ready = 0; fill_done = 1;
    step();
    check("dirty_alloc", {28'd0, allocateWay}, 4'b0010);
    check("dirty_done", {31'd0, done}, 1);
    check("dirty_perr", {31'd0, protocol_err}, 0);
    idleInputs();
    step();

    for (int i = 0; i < 9; i++) runTxn(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for fill data: the miss is dropped without a done pulse.
    req_valid = 1; req_hit = 0; valid_mask = 4'b1110; req_addr = 32'h4000; fill_ready = 1;
    step();
    req_valid = 0;
    step();
    check("rst_in_fill_wait", {31'd0, fill_valid}, 0);
    #2 reset = 1;
    #1;
    checkAllZero("rst_mid");
    fill_done = 1;
    step();
    step();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_no_done", {31'd0, done}, 0);
      check("rst_no_alloc", {28'd0, allocateWay}, 0);
      check("rst_ready", {31'd0, req_ready}, 1);
    end
    idleInputs();
    runTxn(vecs[2], "post_rst");

`ifdef EVICT_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{0, 4'b0000, 32'h5000, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 0, 4'b0000, 0};
      runTxn(tv, "tmo1");
      checks++;
      if (lat < 17 || lat > 19) begin
        failures++;
        $display("FAIL tmo1_latency got=%0d expected=17..19", lat);
      end
      tv.addr = 32'h5040; tv.expAlloc = 4'b0010;
      runTxn(tv, "tmo2");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
